// File: rtl/axle_pkg.sv
// Shared types and constants for the axle counter section.
package axle_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [1:0] DIR_NONE = 2'b00;
    localparam logic [1:0] DIR_A2B  = 2'b01;
    localparam logic [1:0] DIR_B2A  = 2'b10;

    localparam int DEFAULT_WHEELS_PER_BOGEY = 4;

endpackage

// File: rtl/axle_edge_sync.sv
// Two-flop synchroniser followed by a rising-edge detector for one sensor input.
module axle_edge_sync (
    input  logic Clk,
    input  logic Reset,
    input  logic din,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic prev;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= din;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign pulse = sync2 & ~prev;

endmodule

// File: rtl/axle_counter_section.sv
// Wheel/bogey counter between sensors A and B with gate-close hold timer and sticky error.
// Build option: AXLE_EDGE_DETECT_EN adds input synchronisers and rising-edge detection.
module axle_counter_section
    import axle_pkg::*;
#(
    parameter int WHEELS_PER_BOGEY = DEFAULT_WHEELS_PER_BOGEY,
    parameter int CNT_W            = 8,
    parameter int HOLD_CYCLES      = 16,
    localparam int POS_W           = $clog2(WHEELS_PER_BOGEY + 1) + 1,
    localparam int TMR_W           = $clog2(HOLD_CYCLES + 1)
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    a2b,
    input  logic                    b2a,
    input  logic                    clr_err,
    output logic [CNT_W-1:0]        count_a2b,
    output logic [CNT_W-1:0]        count_b2a,
    output logic signed [POS_W-1:0] wheel_pos,
    output logic [1:0]              dir,
    output logic                    gate_close,
    output logic                    err
);

    localparam logic signed [POS_W-1:0] BOGEY_POS = POS_W'(WHEELS_PER_BOGEY);
    localparam logic [CNT_W-1:0]        CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [TMR_W-1:0]        HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);

    logic in_a;
    logic in_b;

`ifdef AXLE_EDGE_DETECT_EN
    axle_edge_sync u_sync_a (.Clk(Clk), .Reset(Reset), .din(a2b), .pulse(in_a));
    axle_edge_sync u_sync_b (.Clk(Clk), .Reset(Reset), .din(b2a), .pulse(in_b));
`else
    assign in_a = a2b;
    assign in_b = b2a;
`endif

    logic ev_a, ev_b, ev_any, ev_both;
    assign ev_a    = in_a & ~in_b;
    assign ev_b    = in_b & ~in_a;
    assign ev_any  = ev_a | ev_b;
    assign ev_both = in_a & in_b;

    state_t                    state, next_state;
    logic [TMR_W-1:0]          timer, timer_nxt;
    logic [CNT_W-1:0]          cnt_a_nxt, cnt_b_nxt;
    logic signed [POS_W-1:0]   pos_nxt;
    logic [1:0]                dir_nxt;
    logic                      sat_err;
    logic                      pos_zero_evt;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        cnt_a_nxt = count_a2b;
        cnt_b_nxt = count_b2a;
        pos_nxt   = wheel_pos;
        dir_nxt   = dir;
        sat_err   = 1'b0;
        if (ev_a) begin
            dir_nxt = DIR_A2B;
            pos_nxt = wheel_pos + POS_W'(1);
            if (pos_nxt == BOGEY_POS) begin
                pos_nxt = '0;
                if (count_b2a != '0)        cnt_b_nxt = count_b2a - CNT_W'(1);
                else if (count_a2b == CNT_MAX) sat_err = 1'b1;
                else                        cnt_a_nxt = count_a2b + CNT_W'(1);
            end
        end else if (ev_b) begin
            dir_nxt = DIR_B2A;
            pos_nxt = wheel_pos - POS_W'(1);
            if (pos_nxt == -BOGEY_POS) begin
                pos_nxt = '0;
                if (count_a2b != '0)        cnt_a_nxt = count_a2b - CNT_W'(1);
                else if (count_b2a == CNT_MAX) sat_err = 1'b1;
                else                        cnt_b_nxt = count_b2a + CNT_W'(1);
            end
        end
    end

    assign pos_zero_evt = ev_any && (pos_nxt == '0);

    // An event that lands the balance on zero always (re)starts the hold period.
    always_comb begin
        next_state = state;
        timer_nxt  = timer;
        if (pos_zero_evt) begin
            next_state = HOLD;
            timer_nxt  = HOLD_LOAD;
        end else begin
            case (state)
                IDLE:   if (ev_any) next_state = ACTIVE;
                ACTIVE: next_state = ACTIVE;
                HOLD: begin
                    if (ev_any)              next_state = ACTIVE;
                    else if (timer == '0)    next_state = IDLE;
                    else                     timer_nxt  = timer - TMR_W'(1);
                end
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            timer      <= '0;
            count_a2b  <= '0;
            count_b2a  <= '0;
            wheel_pos  <= '0;
            dir        <= DIR_NONE;
            gate_close <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= next_state;
            timer      <= timer_nxt;
            count_a2b  <= cnt_a_nxt;
            count_b2a  <= cnt_b_nxt;
            wheel_pos  <= pos_nxt;
            dir        <= dir_nxt;
            gate_close <= (next_state != IDLE);
            if (ev_both || sat_err) err <= 1'b1;
            else if (clr_err)       err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axle_counter_section.sv
// Directed self-checking bench for axle_counter_section (default build or AXLE_EDGE_DETECT_EN).
module tb_axle_counter_section;

    localparam int HOLD = 16;

    logic              Clk = 1'b0;
    logic              Reset = 1'b1;
    logic              a2b = 1'b0, b2a = 1'b0, clr_err = 1'b0;
    logic [7:0]        count_a2b, count_b2a;
    logic signed [3:0] wheel_pos;
    logic [1:0]        dir;
    logic              gate_close, err;
    logic [1:0]        s_count_a2b, s_count_b2a;
    logic signed [3:0] s_wheel_pos;
    logic [1:0]        s_dir;
    logic              s_gate_close, s_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 Clk = ~Clk;

    axle_counter_section dut (
        .Clk(Clk), .Reset(Reset), .a2b(a2b), .b2a(b2a), .clr_err(clr_err),
        .count_a2b(count_a2b), .count_b2a(count_b2a), .wheel_pos(wheel_pos),
        .dir(dir), .gate_close(gate_close), .err(err)
    );

    axle_counter_section #(.CNT_W(2)) dut_sat (
        .Clk(Clk), .Reset(Reset), .a2b(a2b), .b2a(b2a), .clr_err(clr_err),
        .count_a2b(s_count_a2b), .count_b2a(s_count_b2a), .wheel_pos(s_wheel_pos),
        .dir(s_dir), .gate_close(s_gate_close), .err(s_err)
    );

    task automatic do_reset();
        @(negedge Clk);
        a2b = 0; b2a = 0; clr_err = 0; Reset = 1;
        @(negedge Clk);
        Reset = 0;
    endtask

    // Drive one event cycle; returns at the first negedge where its effect is visible.
    task automatic do_event(input logic a, input logic b, input logic c);
        @(negedge Clk);
        a2b = a; b2a = b; clr_err = c;
        @(negedge Clk);
        a2b = 0; b2a = 0; clr_err = 0;
`ifdef AXLE_EDGE_DETECT_EN
        repeat (2) @(negedge Clk);
`endif
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (count_a2b !== 8'd0) begin n_bad++; $display("FAIL reset_count_a2b got %0d want 0", count_a2b); end
        n_cmp++; if (count_b2a !== 8'd0) begin n_bad++; $display("FAIL reset_count_b2a got %0d want 0", count_b2a); end
        n_cmp++; if (wheel_pos !== 4'sd0) begin n_bad++; $display("FAIL reset_wheel_pos got %0d want 0", wheel_pos); end
        n_cmp++; if (dir !== 2'b00) begin n_bad++; $display("FAIL reset_dir got %b want 00", dir); end
        n_cmp++; if (gate_close !== 1'b0) begin n_bad++; $display("FAIL reset_gate got %b want 0", gate_close); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b want 0", err); end
    endtask

    task automatic test_bogey_a2b();
        logic signed [3:0] exp_pos [4] = '{4'sd1, 4'sd2, 4'sd3, 4'sd0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            do_event(1, 0, 0);
            n_cmp++; if (wheel_pos !== exp_pos[i]) begin n_bad++; $display("FAIL a2b_pos[%0d] got %0d want %0d", i, wheel_pos, exp_pos[i]); end
            n_cmp++; if (gate_close !== 1'b1) begin n_bad++; $display("FAIL a2b_gate[%0d] got %b want 1", i, gate_close); end
        end
        n_cmp++; if (count_a2b !== 8'd1) begin n_bad++; $display("FAIL a2b_count got %0d want 1", count_a2b); end
        n_cmp++; if (dir !== 2'b01) begin n_bad++; $display("FAIL a2b_dir got %b want 01", dir); end
        repeat (HOLD - 1) @(negedge Clk);
        n_cmp++; if (gate_close !== 1'b1) begin n_bad++; $display("FAIL hold_last_cycle got %b want 1", gate_close); end
        @(negedge Clk);
        n_cmp++; if (gate_close !== 1'b0) begin n_bad++; $display("FAIL hold_expired got %b want 0", gate_close); end
        n_cmp++; if (count_a2b !== 8'd1) begin n_bad++; $display("FAIL a2b_count_kept got %0d want 1", count_a2b); end
    endtask

    task automatic test_wheel_reversal();
        logic               ev_a [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        logic signed [3:0]  exp_pos [4] = '{4'sd1, 4'sd2, 4'sd1, 4'sd0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            do_event(ev_a[i], !ev_a[i], 0);
            n_cmp++; if (wheel_pos !== exp_pos[i]) begin n_bad++; $display("FAIL rev_pos[%0d] got %0d want %0d", i, wheel_pos, exp_pos[i]); end
        end
        n_cmp++; if (count_a2b !== 8'd0 || count_b2a !== 8'd0) begin n_bad++; $display("FAIL rev_counts got %0d/%0d want 0/0", count_a2b, count_b2a); end
        n_cmp++; if (dir !== 2'b10) begin n_bad++; $display("FAIL rev_dir got %b want 10", dir); end
        n_cmp++; if (gate_close !== 1'b1) begin n_bad++; $display("FAIL rev_gate got %b want 1", gate_close); end
        repeat (HOLD) @(negedge Clk);
        n_cmp++; if (gate_close !== 1'b0) begin n_bad++; $display("FAIL rev_hold_expired got %b want 0", gate_close); end
    endtask

    task automatic test_bogey_reversal();
        do_reset();
        repeat (4) do_event(1, 0, 0);
        n_cmp++; if (count_a2b !== 8'd1) begin n_bad++; $display("FAIL brev_a2b_first got %0d want 1", count_a2b); end
        repeat (4) do_event(0, 1, 0);
        n_cmp++; if (count_a2b !== 8'd0 || count_b2a !== 8'd0) begin n_bad++; $display("FAIL brev_returned got %0d/%0d want 0/0", count_a2b, count_b2a); end
        n_cmp++; if (wheel_pos !== 4'sd0) begin n_bad++; $display("FAIL brev_pos got %0d want 0", wheel_pos); end
        repeat (4) do_event(0, 1, 0);
        n_cmp++; if (count_b2a !== 8'd1 || count_a2b !== 8'd0) begin n_bad++; $display("FAIL brev_b2a got %0d/%0d want 0/1", count_a2b, count_b2a); end
        n_cmp++; if (dir !== 2'b10) begin n_bad++; $display("FAIL brev_dir got %b want 10", dir); end
    endtask

    task automatic test_both_high();
        do_reset();
        repeat (2) do_event(1, 0, 0);
        do_event(1, 1, 0);
        n_cmp++; if (wheel_pos !== 4'sd2) begin n_bad++; $display("FAIL both_pos got %0d want 2", wheel_pos); end
        n_cmp++; if (count_a2b !== 8'd0 || count_b2a !== 8'd0) begin n_bad++; $display("FAIL both_counts got %0d/%0d want 0/0", count_a2b, count_b2a); end
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL both_err got %b want 1", err); end
        n_cmp++; if (dir !== 2'b01) begin n_bad++; $display("FAIL both_dir got %b want 01", dir); end
        do_event(0, 0, 1);
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL clr_err got %b want 0", err); end
`ifndef AXLE_EDGE_DETECT_EN
        do_event(1, 1, 1);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_beats_clr got %b want 1", err); end
`endif
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
        logic       exp_err [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        do_reset();
        for (int b = 0; b < 4; b++) begin
            repeat (4) do_event(1, 0, 0);
            n_cmp++; if (s_count_a2b !== exp_cnt[b]) begin n_bad++; $display("FAIL sat_count[%0d] got %0d want %0d", b, s_count_a2b, exp_cnt[b]); end
            n_cmp++; if (s_err !== exp_err[b]) begin n_bad++; $display("FAIL sat_err[%0d] got %b want %b", b, s_err, exp_err[b]); end
        end
        n_cmp++; if (s_wheel_pos !== 4'sd0) begin n_bad++; $display("FAIL sat_pos got %0d want 0", s_wheel_pos); end
        n_cmp++; if (count_a2b !== 8'd4) begin n_bad++; $display("FAIL wide_count got %0d want 4", count_a2b); end
    endtask

    task automatic test_level_input();
        do_reset();
        @(negedge Clk);
`ifdef AXLE_EDGE_DETECT_EN
        a2b = 1;
        repeat (10) @(negedge Clk);
        a2b = 0;
        repeat (3) @(negedge Clk);
        n_cmp++; if (wheel_pos !== 4'sd1) begin n_bad++; $display("FAIL level_once got %0d want 1", wheel_pos); end
`else
        a2b = 1;
        repeat (3) @(negedge Clk);
        a2b = 0;
        n_cmp++; if (wheel_pos !== 4'sd3) begin n_bad++; $display("FAIL level_each_cycle got %0d want 3", wheel_pos); end
`endif
    endtask

    task automatic test_async_reset();
        do_reset();
        repeat (2) do_event(1, 0, 0);
        n_cmp++; if (wheel_pos !== 4'sd2) begin n_bad++; $display("FAIL pre_reset_pos got %0d want 2", wheel_pos); end
        @(negedge Clk);
        #2 Reset = 1;
        #1;
        n_cmp++; if (wheel_pos !== 4'sd0 || gate_close !== 1'b0 || dir !== 2'b00)
            begin n_bad++; $display("FAIL async_reset got pos=%0d gate=%b dir=%b want 0/0/00", wheel_pos, gate_close, dir); end
        @(negedge Clk);
        Reset = 0;
    endtask

    initial begin
        test_reset();
        test_bogey_a2b();
        test_wheel_reversal();
        test_bogey_reversal();
        test_both_high();
        test_saturation();
        test_level_input();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
